// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-way round-robin arbiter with one-hot and encoded grant.
//
// A grant is held until the owner releases it (done), withdraws its request,
// or the arbiter is disabled. Every release passes through one IDLE cycle,
// and the scan pointer moves to the agent just after the released owner.
//
// Build option RR_TIMEOUT_EN: when defined, a hold counter force-releases a
// grant after MAX_HOLD cycles and pulses `timeout`. When undefined, grants
// are held indefinitely and `timeout` stays 0.
//
// state | meaning
// IDLE  | no owner; scan req from ptr and grant on the next edge
// GRANT | gnt/gnt_id/gnt_valid hold the current owner until release

module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_max_hold_range
        $error("rr_arbiter_8: MAX_HOLD must be in 2..256");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic [2:0] pick_id;
    logic       pick_ok;
    logic [2:0] cand;
    logic       owner_drop;

`ifdef RR_TIMEOUT_EN
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_hit;

    assign hold_hit = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
`endif

    // Rotating priority scan: first set request at ptr, ptr+1, ... ptr+7.
    always_comb begin
        pick_ok = 1'b0;
        pick_id = ptr;
        cand    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr + 3'(i);
            if (!pick_ok && req[cand]) begin
                pick_ok = 1'b1;
                pick_id = cand;
            end
        end
    end

    // Any of these ends the current grant; done wins over the hold limit.
    assign owner_drop = done | ~req[gnt_id] | ~en;

    // Arbiter FSM with registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            ptr       <= 3'd0;
`ifdef RR_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick_ok) begin
                        gnt_id    <= pick_id;
                        gnt       <= 8'(1) << pick_id;
                        gnt_valid <= 1'b1;
                        state     <= GRANT;
`ifdef RR_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (owner_drop) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 3'd1;
                        state     <= IDLE;
`ifdef RR_TIMEOUT_EN
                    end else if (hold_hit) begin
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_id + 3'd1;
                        timeout   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        hold_cnt  <= hold_cnt + HOLD_W'(1);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus a randomized run
// checked against a behavioural model of the round-robin rules.

module tb_rr_arbiter_8;

`ifdef RR_TIMEOUT_EN
    localparam int MH    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int MH    = 16;
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    bit m_valid;
    int m_id;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    always #5 clk = ~clk;

    rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_valid   = 1'b0;
        m_id      = 0;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    // One clock of the arbitration rules, using the inputs presented this cycle.
    task automatic model_step();
        int idx;
        m_timeout = 1'b0;
        if (!m_valid) begin
            if (en && req != 8'h00) begin
                for (int k = 0; k < 8; k++) begin
                    idx = (m_ptr + k) % 8;
                    if (req[idx]) begin
                        m_id    = idx;
                        m_valid = 1'b1;
                        m_hold  = 0;
                        break;
                    end
                end
            end
        end else if (done || !req[m_id] || !en) begin
            m_valid = 1'b0;
            m_ptr   = (m_id + 1) % 8;
        end else if (TO_EN && m_hold == MH - 1) begin
            m_valid   = 1'b0;
            m_ptr     = (m_id + 1) % 8;
            m_timeout = 1'b1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
        model_reset();
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: gnt=%h valid=%b id=%0d timeout=%b, required 00/0/0/0", gnt, gnt_valid, gnt_id, timeout);
        end
        #2 rst = 1'b0;
        en = 1'b1; req = 8'h10;
        step();
        checks++;
        if (gnt !== 8'h10 || gnt_id !== 3'd4) begin
            errors++;
            $display("FAIL reset_pre_grant: gnt=%h id=%0d, required 10/4", gnt, gnt_id);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: gnt=%h valid=%b id=%0d, required 00/0/0", gnt, gnt_valid, gnt_id);
        end
        model_reset();
        req = 8'h01;
        #1 rst = 1'b0;
        step();
        checks++;
        if (gnt !== 8'h01 || gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_ptr_zero: gnt=%h id=%0d valid=%b, required 01/0/1", gnt, gnt_id, gnt_valid);
        end
    endtask

    task automatic test_single();
        int hold_n;
        hold_n = TO_EN ? MH - 2 : 5;
        req = 8'h00; done = 1'b0; en = 1'b1;
        step();
        step();
        req = 8'h20;
        step();
        checks++;
        if (gnt !== 8'h20 || gnt_id !== 3'd5 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: gnt=%h id=%0d valid=%b, required 20/5/1", gnt, gnt_id, gnt_valid);
        end
        for (int i = 0; i < hold_n; i++) begin
            step();
            checks++;
            if (gnt !== 8'h20) begin
                errors++;
                $display("FAIL single_hold[%0d]: gnt=%h, required 20", i, gnt);
            end
        end
        done = 1'b1;
        step();
        done = 1'b0;
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: gnt=%h valid=%b, required 00/0", gnt, gnt_valid);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_gnt;
        int wrap_seq [3] = '{7, 0, 7};
        apply_reset();
        en = 1'b1; req = 8'hFF; done = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            exp_gnt = 8'(1) << (k % 8);
            checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 3'(k % 8) || gnt !== exp_gnt) begin
                errors++;
                $display("FAIL fair_order[%0d]: valid=%b id=%0d gnt=%h, required 1/%0d/%h", k, gnt_valid, gnt_id, gnt, k % 8, exp_gnt);
            end
            step();
            checks++;
            if (gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL fair_gap[%0d]: valid=%b, required 0", k, gnt_valid);
            end
        end
        req = 8'h81;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (gnt_valid !== 1'b1 || gnt_id !== 3'(wrap_seq[k])) begin
                errors++;
                $display("FAIL fair_wrap[%0d]: valid=%b id=%0d, required 1/%0d", k, gnt_valid, gnt_id, wrap_seq[k]);
            end
            step();
        end
        done = 1'b0; req = 8'h00;
        step();
    endtask

    task automatic test_enable();
        en = 1'b1; req = 8'h08;
        step();
        checks++;
        if (gnt_id !== 3'd3 || gnt !== 8'h08) begin
            errors++;
            $display("FAIL en_grant: id=%0d gnt=%h, required 3/08", gnt_id, gnt);
        end
        en = 1'b0;
        step();
        checks++;
        if (gnt !== 8'h00) begin
            errors++;
            $display("FAIL en_revoke: gnt=%h, required 00", gnt);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL en_blocked[%0d]: gnt=%h valid=%b, required 00/0", i, gnt, gnt_valid);
            end
        end
        en = 1'b1;
        step();
        checks++;
        if (gnt_id !== 3'd3 || gnt !== 8'h08) begin
            errors++;
            $display("FAIL en_regrant: id=%0d gnt=%h, required 3/08", gnt_id, gnt);
        end
        req = 8'h00;
        step();
        checks++;
        if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL withdraw_release: gnt=%h valid=%b, required 00/0", gnt, gnt_valid);
        end
        step();
    endtask

    task automatic test_simultaneous();
        req = 8'h40;
        step();
        checks++;
        if (gnt_id !== 3'd6) begin
            errors++;
            $display("FAIL sim_own6: id=%0d, required 6", gnt_id);
        end
        done = 1'b1; req = 8'hC4;
        step();
        done = 1'b0;
        checks++;
        if (gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_release: valid=%b, required 0", gnt_valid);
        end
        step();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_id !== 3'd7) begin
            errors++;
            $display("FAIL sim_next7: valid=%b id=%0d, required 1/7", gnt_valid, gnt_id);
        end
        req = 8'h00;
        step();
        req = 8'h40;
        step();
        done = 1'b1; req = 8'h44;
        step();
        done = 1'b0;
        step();
        checks++;
        if (gnt_valid !== 1'b1 || gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL sim_next2: valid=%b id=%0d, required 1/2", gnt_valid, gnt_id);
        end
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_timeout();
        int n;
        int to_cnt;
        en = 1'b1; done = 1'b0; req = 8'h02;
        step();
        checks++;
        if (gnt_id !== 3'd1 || gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL to_grant1: id=%0d valid=%b, required 1/1", gnt_id, gnt_valid);
        end
        n = 1;
        to_cnt = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (timeout) to_cnt++;
            if (!gnt_valid) break;
            n++;
        end
`ifdef RR_TIMEOUT_EN
        checks++;
        if (n != MH) begin
            errors++;
            $display("FAIL to_hold_len: held %0d cycles, required %0d", n, MH);
        end
        checks++;
        if (to_cnt != 1 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_pulse: pulses=%0d timeout_at_fall=%b, required 1/1", to_cnt, timeout);
        end
        req = 8'h06;
        step();
        checks++;
        if (gnt_id !== 3'd2) begin
            errors++;
            $display("FAIL to_ptr: next id=%0d, required 2", gnt_id);
        end
`else
        checks++;
        if (n != 51) begin
            errors++;
            $display("FAIL hold_forever: held %0d cycles, required 51", n);
        end
        checks++;
        if (to_cnt != 0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: pulses=%0d timeout=%b, required 0/0", to_cnt, timeout);
        end
        done = 1'b1;
        step();
        done = 1'b0;
`endif
        req = 8'h00;
        step();
        step();
    endtask

    task automatic test_random();
        logic [7:0] exp_gnt;
        apply_reset();
        req = 8'h00; en = 1'b1; done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) req = 8'($urandom());
            en   = ($urandom_range(0, 9) != 0);
            done = ($urandom_range(0, 5) == 0);
            step();
            exp_gnt = m_valid ? (8'(1) << m_id) : 8'h00;
            checks++;
            if (gnt !== exp_gnt || gnt_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_gnt[%0d]: gnt=%h valid=%b, required %h/%b", i, gnt, gnt_valid, exp_gnt, m_valid);
            end
            checks++;
            if (gnt_id !== 3'(m_id)) begin
                errors++;
                $display("FAIL rand_id[%0d]: id=%0d, required %0d", i, gnt_id, m_id);
            end
            checks++;
            if (timeout !== m_timeout) begin
                errors++;
                $display("FAIL rand_timeout[%0d]: timeout=%b, required %b", i, timeout, m_timeout);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_enable();
        test_simultaneous();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
